// File: rtl/julia_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : julia_pkg                                                    |
// | Description : Shared constants and types for the Julia-set pixel pipeline. |
// |               Holds the iterator state encoding, the Q-format defaults and |
// |               the fixed-point reference values used by neighbouring stages.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package julia_pkg;

  // Default Q10.10 number format and iteration cap for the pixel pipeline.
  localparam int DEFAULT_WIDTH      = 20;
  localparam int DEFAULT_FRACTIONAL = 10;
  localparam int DEFAULT_INTEGRAL   = 10;
  localparam int DEFAULT_MAX_ITER   = 64;

  // 1.0 and the 4.0 escape radius (squared magnitude) in the default format.
  localparam int FIXED_ONE = 1 << DEFAULT_FRACTIONAL;
  localparam int ESCAPE_SQ = 4 << DEFAULT_FRACTIONAL;

  // Iterator control states, explicitly encoded.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ITERATE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage : julia_pkg
`default_nettype wire

// File: rtl/pixel_calculator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_calculator                                             |
// | Description : Combinational single step z' = z^2 + c in signed fixed point |
// |               with escape test |z'|^2 >= 4.0. The count is incremented     |
// |               only when the new point has not escaped.                     |
// | Ports       : i_z_real/i_z_imag  current z                                 |
// |               i_c_real/i_c_imag  Julia constant c                          |
// |               i_iteration        iteration count before this step          |
// |               o_z_real/o_z_imag  new z (wrap-around)                       |
// |               o_iteration        i_iteration, +1 unless the point escaped  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_calculator #(
  parameter int WIDTH      = 20,
  parameter int FRACTIONAL = 10,
  parameter int INTEGRAL   = 10
) (
  input  logic [WIDTH-1:0] i_z_real,
  input  logic [WIDTH-1:0] i_z_imag,
  input  logic [WIDTH-1:0] i_c_real,
  input  logic [WIDTH-1:0] i_c_imag,
  input  logic [7:0]       i_iteration,
  output logic [WIDTH-1:0] o_z_real,
  output logic [WIDTH-1:0] o_z_imag,
  output logic [7:0]       o_iteration
);

  // Wide enough for a full-precision sum of two squared WIDTH-bit values, so
  // neither the product terms nor the magnitude can wrap.
  localparam int c_EXT_W = 2 * (INTEGRAL + FRACTIONAL) + 1;
  localparam logic signed [c_EXT_W-1:0] c_ESCAPE_MAG =
    c_EXT_W'(4) <<< (2 * FRACTIONAL);

  logic signed [c_EXT_W-1:0] w_zr;
  logic signed [c_EXT_W-1:0] w_zi;
  logic signed [c_EXT_W-1:0] w_re_full;
  logic signed [c_EXT_W-1:0] w_im_full;
  logic signed [c_EXT_W-1:0] w_nr;
  logic signed [c_EXT_W-1:0] w_ni;
  logic signed [c_EXT_W-1:0] w_mag;
  logic [WIDTH-1:0]          w_re_trunc;
  logic [WIDTH-1:0]          w_im_trunc;
  logic                      w_escape;

  assign w_zr = {{(c_EXT_W-WIDTH){i_z_real[WIDTH-1]}}, i_z_real};
  assign w_zi = {{(c_EXT_W-WIDTH){i_z_imag[WIDTH-1]}}, i_z_imag};

  // Rescale after the subtraction so only one truncation is applied.
  assign w_re_full  = (w_zr * w_zr) - (w_zi * w_zi);
  assign w_im_full  = (w_zr * w_zi) <<< 1;
  assign w_re_trunc = WIDTH'(w_re_full >>> FRACTIONAL);
  assign w_im_trunc = WIDTH'(w_im_full >>> FRACTIONAL);

  // Adding c in WIDTH bits gives the wrap-around behaviour directly.
  assign o_z_real = w_re_trunc + i_c_real;
  assign o_z_imag = w_im_trunc + i_c_imag;

  // The escape test uses the wrapped new z, compared at full precision.
  assign w_nr     = {{(c_EXT_W-WIDTH){o_z_real[WIDTH-1]}}, o_z_real};
  assign w_ni     = {{(c_EXT_W-WIDTH){o_z_imag[WIDTH-1]}}, o_z_imag};
  assign w_mag    = (w_nr * w_nr) + (w_ni * w_ni);
  assign w_escape = (w_mag >= c_ESCAPE_MAG);

  assign o_iteration = w_escape ? i_iteration : (i_iteration + 8'd1);

endmodule : pixel_calculator
`default_nettype wire

// File: rtl/julia_pixel_iterator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : julia_pixel_iterator                                         |
// | Description : Sequential driver for pixel_calculator. Accepts one pixel    |
// |               job, runs one z = z^2 + c step per clock until escape or     |
// |               MAX_ITER, then presents count and tag on a valid/ready port. |
// | Ports       : clk, rst                  clock, sync active-high reset      |
// |               in_valid/in_ready         job handshake                      |
// |               z_*_init, c_*, tag_in     job payload (sampled on accept)    |
// |               out_valid/out_ready       result handshake                   |
// |               out_iteration, out_tag    result payload                     |
// |               busy                      high whenever not idle             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module julia_pixel_iterator
  import julia_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FRACTIONAL = DEFAULT_FRACTIONAL,
  parameter int INTEGRAL   = DEFAULT_INTEGRAL,
  parameter int MAX_ITER   = DEFAULT_MAX_ITER,
  parameter int TAG_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     z_real_init,
  input  logic [WIDTH-1:0]     z_imag_init,
  input  logic [WIDTH-1:0]     c_real,
  input  logic [WIDTH-1:0]     c_imag,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_iteration,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam logic [7:0] c_MAX_ITER = 8'(MAX_ITER);

  state_e               r_state;
  logic [WIDTH-1:0]     r_z_real;
  logic [WIDTH-1:0]     r_z_imag;
  logic [WIDTH-1:0]     r_c_real;
  logic [WIDTH-1:0]     r_c_imag;
  logic [7:0]           r_iter;
  logic [TAG_WIDTH-1:0] r_tag;

  logic [WIDTH-1:0]     w_z_real_nxt;
  logic [WIDTH-1:0]     w_z_imag_nxt;
  logic [7:0]           w_iter_nxt;
  logic                 w_escape;

  pixel_calculator #(
    .WIDTH      (WIDTH),
    .FRACTIONAL (FRACTIONAL),
    .INTEGRAL   (INTEGRAL)
  ) u_calc (
    .i_z_real    (r_z_real),
    .i_z_imag    (r_z_imag),
    .i_c_real    (r_c_real),
    .i_c_imag    (r_c_imag),
    .i_iteration (r_iter),
    .o_z_real    (w_z_real_nxt),
    .o_z_imag    (w_z_imag_nxt),
    .o_iteration (w_iter_nxt)
  );

  // The calculator withholds the increment exactly when the new point escapes.
  assign w_escape = (w_iter_nxt == r_iter);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_z_real <= '0;
      r_z_imag <= '0;
      r_c_real <= '0;
      r_c_imag <= '0;
      r_iter   <= '0;
      r_tag    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_z_real <= z_real_init;
            r_z_imag <= z_imag_init;
            r_c_real <= c_real;
            r_c_imag <= c_imag;
            r_tag    <= tag_in;
            r_iter   <= '0;
            r_state  <= ST_ITERATE;
          end
        end
        ST_ITERATE: begin
          // Escape wins over the cap: the count is left untouched.
          if (w_escape) begin
            r_state <= ST_DONE;
          end else begin
            r_z_real <= w_z_real_nxt;
            r_z_imag <= w_z_imag_nxt;
            r_iter   <= w_iter_nxt;
            if (w_iter_nxt == c_MAX_ITER) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Returning to IDLE first keeps result and next accept a cycle apart.
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_DONE);
  assign busy          = (r_state != ST_IDLE);
  assign out_iteration = r_iter;
  assign out_tag       = r_tag;

endmodule : julia_pixel_iterator
`default_nettype wire

// File: tb/tb_julia_pixel_iterator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_julia_pixel_iterator                                      |
// | Description : Self-checking bench for julia_pixel_iterator. A cycle-level  |
// |               behavioural model (plain integer arithmetic) predicts the    |
// |               handshake signals and results every cycle; directed jobs     |
// |               pin the model with hand-computed values.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_julia_pixel_iterator;

  localparam int W    = 20;
  localparam int F    = 10;
  localparam int MAXI = 64;
  localparam int TW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  z_real_init;
  logic [W-1:0]  z_imag_init;
  logic [W-1:0]  c_real;
  logic [W-1:0]  c_imag;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_iteration;
  logic [TW-1:0] out_tag;
  logic          busy;

  int checks = 0;
  int errors = 0;

  julia_pixel_iterator #(
    .WIDTH(W), .FRACTIONAL(F), .INTEGRAL(10), .MAX_ITER(MAXI), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z_real_init(z_real_init), .z_imag_init(z_imag_init),
    .c_real(c_real), .c_imag(c_imag), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iteration(out_iteration), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  // Mathematical reference: iterate z^2 + c with W-bit wrap; returns the
  // final count and the number of clocked steps taken.
  function automatic void model(input longint zr0, input longint zi0,
                                input longint cr, input longint ci,
                                output int iter, output int steps);
    longint zr, zi, nr, ni;
    zr = zr0; zi = zi0; iter = 0; steps = 0;
    for (int s = 0; s < MAXI; s++) begin
      nr = wrapw(((zr * zr - zi * zi) >>> F) + cr);
      ni = wrapw(((2 * zr * zi) >>> F) + ci);
      steps++;
      if (nr * nr + ni * ni >= (64'sd4 <<< (2 * F))) return;
      iter++;
      zr = nr; zi = ni;
    end
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // ---------------- cycle model + compare process ----------------
  bit         m_valid = 0;
  bit         m_rst_just = 0;
  int         m_phase = 0;   // 0 idle, 1 computing, 2 result pending
  int         m_left = 0;
  int         m_iter = 0;
  logic [TW-1:0] m_tag = '0;

  always @(negedge clk) begin
    int st;
    if (m_valid) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_rst_just) begin
        chk("reset_out_iteration", out_iteration, 0);
        chk("reset_out_tag", out_tag, 0);
      end
      if (m_phase == 2) begin
        chk("out_iteration", out_iteration, m_iter);
        chk("out_tag", out_tag, m_tag);
      end
    end
    m_rst_just = 0;
    if (rst) begin
      m_valid = 1; m_phase = 0; m_rst_just = 1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (in_valid) begin
             model(sx(z_real_init), sx(z_imag_init), sx(c_real), sx(c_imag), m_iter, st);
             m_tag = tag_in; m_left = st; m_phase = 1;
           end
        1: begin m_left--; if (m_left == 0) m_phase = 2; end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic randomize_inputs();
    z_real_init = 20'($urandom); z_imag_init = 20'($urandom);
    c_real = 20'($urandom); c_imag = 20'($urandom); tag_in = 16'($urandom);
  endtask

  // Entered and left at posedge+1. Presents a job, waits for its result,
  // applies `hold` cycles of back-pressure and completes the handshake.
  task automatic run_job(input logic [W-1:0] zr, input logic [W-1:0] zi,
                         input logic [W-1:0] cr, input logic [W-1:0] ci,
                         input logic [TW-1:0] tag, input int hold,
                         input bit scramble, input bit valid_in_done,
                         output int iter_o, output int lat_o, output int wait_o);
    int exp_it, exp_st, n;
    model(sx(zr), sx(zi), sx(cr), sx(ci), exp_it, exp_st);
    z_real_init = zr; z_imag_init = zi; c_real = cr; c_imag = ci; tag_in = tag;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    wait_o = n;
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_o = 0;
    iter_o = -1;
    forever begin
      if (scramble) begin randomize_inputs(); in_valid = 1'($urandom); end
      @(negedge clk);
      lat_o++;
      if (out_valid || lat_o > 300) break;
      @(posedge clk); #1;
    end
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
    end else begin
      iter_o = out_iteration;
      chk("job_latency", lat_o, exp_st + 1);
      if (hold > 0) begin
        for (int h = 1; h < hold; h++) begin
          @(posedge clk); #1;
          if (valid_in_done) begin randomize_inputs(); in_valid = 1'b1; end
          @(negedge clk);
          chk("hold_iteration", out_iteration, exp_it);
          chk("hold_tag", out_tag, tag);
          chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (valid_in_done) in_valid = 1'b1;
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    if (!valid_in_done) in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int it, lat, wt, mi, ms;
    logic [W-1:0] zr, zi, cr, ci;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    z_real_init = '0; z_imag_init = '0; c_real = '0; c_imag = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_iteration", out_iteration, 0);
    chk("rst_out_tag", out_tag, 0);
    @(posedge clk); #1;

    // Hand-computed pins of the reference model.
    model(64'sh800, 0, 0, 0, mi, ms);
    chk("model_esc_first_iter", mi, 0);  chk("model_esc_first_steps", ms, 1);
    model(0, 0, 64'sh400, 0, mi, ms);
    chk("model_two_iter", mi, 1);        chk("model_two_steps", ms, 2);
    model(64'sh400, 0, 0, 0, mi, ms);
    chk("model_cap_iter", mi, 64);       chk("model_cap_steps", ms, 64);

    // z0=2.0: escapes on the first step.
    run_job(20'h00800, 0, 0, 0, 16'h0A0A, 0, 0, 0, it, lat, wt);
    chk("esc_first_iter", it, 0);  chk("esc_first_lat", lat, 2);
    // c=1.0: z1=1.0, z2=2.0 escapes on |z|^2 == 4.0.
    run_job(0, 0, 20'h00400, 0, 16'h0B0B, 0, 0, 0, it, lat, wt);
    chk("two_step_iter", it, 1);   chk("two_step_lat", lat, 3);
    // z0=1.0, c=0: fixed point, runs to the cap.
    run_job(20'h00400, 0, 0, 0, 16'h0C0C, 0, 0, 0, it, lat, wt);
    chk("cap_iter", it, 64);       chk("cap_lat", lat, 65);

    // Back-pressure with a new job offered during DONE.
    run_job(0, 0, 20'h00400, 0, 16'hBEEF, 5, 0, 1, it, lat, wt);
    chk("bp_iter", it, 1);
    run_job(20'h00800, 0, 0, 0, 16'h1234, 0, 0, 0, it, lat, wt);
    chk("bp_next_accept_wait", wt, 1);
    chk("bp_next_iter", it, 0);

    // Reset during step 10 of the capped job.
    z_real_init = 20'h00400; z_imag_init = 0; c_real = 0; c_imag = 0; tag_in = 16'hDEAD;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_iteration", out_iteration, 0);
    repeat (80) @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back jobs, inputs scrambled while iterating.
    run_job(0, 0, 20'h00400, 0, 16'h0001, 0, 1, 0, it, lat, wt);
    chk("b2b_first_iter", it, 1);
    run_job(20'h00800, 0, 0, 0, 16'h0002, 0, 1, 0, it, lat, wt);
    chk("b2b_second_iter", it, 0);

    // Random jobs inside the interesting |z|,|c| <= 2.0 region.
    for (int j = 0; j < 40; j++) begin
      zr = 20'($urandom_range(0, 4096) - 2048);
      zi = 20'($urandom_range(0, 4096) - 2048);
      cr = 20'($urandom_range(0, 2048) - 1024);
      ci = 20'($urandom_range(0, 2048) - 1024);
      run_job(zr, zi, cr, ci, 16'($urandom), int'($urandom_range(0, 3)), 1, 0, it, lat, wt);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_julia_pixel_iterator
`default_nettype wire
